// File: rtl/uart_io_ctrl.sv
//-----------------------------------------------------------------------------
// uart_io_ctrl
//
// Memory-mapped UART controller sitting between the CPU IO load/store path
// and a UART core. Transmit and receive bytes are buffered in two small
// FIFOs so the CPU never has to hit a UART handshake cycle exactly. Load
// results are registered, and error flags are sticky until a status read.
//
// Address map (relative to BASE):
//   0x0 status  (R)  {28'b0, tx_drop, rx_ovf, rx_nonempty, tx_notfull}
//                    reading clears tx_drop and rx_ovf
//   0x4 rx data (R)  {24'b0, rx_head}, pops one byte when non-empty
//   0x8 tx data (W)  pushes WriteData[7:0]
//   0xC count   (R)  {16'b0, rx_count[7:0], tx_count[7:0]} (saturated)
//   other            loads 0, stores ignored
//
// Ports:
//   Clock             system clock, rising edge
//   Reset             asynchronous active-low reset
//   Addr              CPU IO address
//   WriteData         CPU store data (only [7:0] used)
//   IOWrite / IORead  one-cycle store / load strobes, level-sampled
//   ReadData          registered load result, held until the next load
//   UartDataIn        byte to the UART transmitter (TX FIFO head)
//   UartDataInValid   TX FIFO non-empty
//   UartDataInReady   UART transmitter ready
//   UartDataOut       byte from the UART receiver
//   UartDataOutValid  received byte valid
//   UartDataOutReady  always 1; overflow is handled by dropping + rx_ovf
//-----------------------------------------------------------------------------
module uart_io_ctrl #(
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned RX_DEPTH = 4,
  parameter logic [31:0] BASE     = 32'h8000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic        IOWrite,
  input  logic        IORead,
  output logic [31:0] ReadData,
  output logic [7:0]  UartDataIn,
  output logic        UartDataInValid,
  input  logic        UartDataInReady,
  input  logic [7:0]  UartDataOut,
  input  logic        UartDataOutValid,
  output logic        UartDataOutReady
);

  //---------------------------------------------------------------------------
  // Derived sizes
  //---------------------------------------------------------------------------
  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned TX_CW = TX_AW + 1;
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned RX_CW = RX_AW + 1;

  localparam logic [TX_CW-1:0] TX_FULL = TX_CW'(TX_DEPTH);
  localparam logic [RX_CW-1:0] RX_FULL = RX_CW'(RX_DEPTH);

  //---------------------------------------------------------------------------
  // State
  //---------------------------------------------------------------------------
  logic [7:0]       tx_mem_q [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
  logic [TX_AW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
  logic [TX_CW-1:0] tx_count_q,  tx_count_d;

  logic [7:0]       rx_mem_q [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
  logic [RX_AW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
  logic [RX_CW-1:0] rx_count_q,  rx_count_d;

  logic             tx_drop_q, tx_drop_d;
  logic             rx_ovf_q,  rx_ovf_d;
  logic [31:0]      read_data_q, read_data_d;

  //---------------------------------------------------------------------------
  // Address decode
  //---------------------------------------------------------------------------
  logic sel_status, sel_rx, sel_tx, sel_count;

  always_comb begin
    sel_status = (Addr == BASE);
    sel_rx     = (Addr == BASE + 32'h4);
    sel_tx     = (Addr == BASE + 32'h8);
    sel_count  = (Addr == BASE + 32'hC);
  end

  // Upper store bits carry no meaning for this block.
  logic wdata_unused;
  assign wdata_unused = ^WriteData[31:8];

  //---------------------------------------------------------------------------
  // FIFO status
  //---------------------------------------------------------------------------
  logic tx_full, tx_notfull, tx_nonempty;
  logic rx_full, rx_nonempty;

  always_comb begin
    tx_full     = (tx_count_q == TX_FULL);
    tx_notfull  = !tx_full;
    tx_nonempty = (tx_count_q != '0);
    rx_full     = (rx_count_q == RX_FULL);
    rx_nonempty = (rx_count_q != '0);
  end

  //---------------------------------------------------------------------------
  // Push / pop qualification
  //
  // When full, a pop on the same edge frees the slot the push needs, so the
  // push is accepted rather than dropped. Pointers wrap naturally because
  // the depths are powers of two.
  //---------------------------------------------------------------------------
  logic tx_push_req, tx_push, tx_pop, tx_drop_evt;
  logic rx_push_req, rx_push, rx_pop, rx_ovf_evt;
  logic status_rd;

  always_comb begin
    tx_pop      = tx_nonempty && UartDataInReady;
    tx_push_req = IOWrite && sel_tx;
    tx_push     = tx_push_req && (!tx_full || tx_pop);
    tx_drop_evt = tx_push_req && !tx_push;

    rx_pop      = IORead && sel_rx && rx_nonempty;
    rx_push_req = UartDataOutValid && UartDataOutReady;
    rx_push     = rx_push_req && (!rx_full || rx_pop);
    rx_ovf_evt  = rx_push_req && !rx_push;

    status_rd   = IORead && sel_status;
  end

  //---------------------------------------------------------------------------
  // Next-state: TX FIFO pointers and count
  //---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, otherwise a
    // path that skips the assignment infers a latch.
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_count_d  = tx_count_q;

    if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + TX_AW'(1);
    if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + TX_AW'(1);

    case ({tx_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + TX_CW'(1);
      2'b01:   tx_count_d = tx_count_q - TX_CW'(1);
      default: tx_count_d = tx_count_q;
    endcase
  end

  //---------------------------------------------------------------------------
  // Next-state: RX FIFO pointers and count
  //---------------------------------------------------------------------------
  always_comb begin
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_count_d  = rx_count_q;

    if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + RX_AW'(1);
    if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + RX_AW'(1);

    case ({rx_push, rx_pop})
      2'b10:   rx_count_d = rx_count_q + RX_CW'(1);
      2'b01:   rx_count_d = rx_count_q - RX_CW'(1);
      default: rx_count_d = rx_count_q;
    endcase
  end

  //---------------------------------------------------------------------------
  // Sticky error flags
  //
  // A status read clears both flags, but an error event on that same edge
  // takes priority so the event is never lost.
  //---------------------------------------------------------------------------
  always_comb begin
    tx_drop_d = (tx_drop_q && !status_rd) || tx_drop_evt;
    rx_ovf_d  = (rx_ovf_q  && !status_rd) || rx_ovf_evt;
  end

  //---------------------------------------------------------------------------
  // Count fields, saturated to 8 bits for reporting
  //---------------------------------------------------------------------------
  logic [31:0] tx_count_ext, rx_count_ext;
  logic [7:0]  tx_count8, rx_count8;

  always_comb begin
    tx_count_ext = 32'(tx_count_q);
    rx_count_ext = 32'(rx_count_q);
    tx_count8    = (tx_count_ext > 32'd255) ? 8'hFF : tx_count_ext[7:0];
    rx_count8    = (rx_count_ext > 32'd255) ? 8'hFF : rx_count_ext[7:0];
  end

  //---------------------------------------------------------------------------
  // Load data mux
  //
  // All fields come from current register values, i.e. the state before
  // this edge's updates. ReadData only changes on a load.
  //---------------------------------------------------------------------------
  logic [7:0] rx_head;
  assign rx_head = rx_mem_q[rx_rd_ptr_q];

  always_comb begin
    read_data_d = read_data_q;
    if (IORead) begin
      if (sel_status) begin
        read_data_d = {28'b0, tx_drop_q, rx_ovf_q, rx_nonempty, tx_notfull};
      end else if (sel_rx) begin
        read_data_d = rx_nonempty ? {24'b0, rx_head} : 32'b0;
      end else if (sel_count) begin
        read_data_d = {16'b0, rx_count8, tx_count8};
      end else begin
        read_data_d = 32'b0;
      end
    end
  end

  //---------------------------------------------------------------------------
  // Control registers
  //---------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
      tx_drop_q   <= 1'b0;
      rx_ovf_q    <= 1'b0;
      read_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value of the others, matching real register behaviour.
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_count_q  <= tx_count_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_count_q  <= rx_count_d;
      tx_drop_q   <= tx_drop_d;
      rx_ovf_q    <= rx_ovf_d;
      read_data_q <= read_data_d;
    end
  end

  //---------------------------------------------------------------------------
  // FIFO storage
  //---------------------------------------------------------------------------
  // NOTE: storage arrays have no reset; entries are only visible behind a
  // non-zero count, so clearing pointers and counts is enough to flush.
  always_ff @(posedge Clock) begin
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= WriteData[7:0];
  end

  always_ff @(posedge Clock) begin
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= UartDataOut;
  end

  //---------------------------------------------------------------------------
  // Outputs
  //
  // UartDataInValid is decoded straight from the count register, so an
  // asserted Reset drops it immediately without waiting for a clock.
  //---------------------------------------------------------------------------
  assign ReadData         = read_data_q;
  assign UartDataIn       = tx_mem_q[tx_rd_ptr_q];
  assign UartDataInValid  = tx_nonempty;
  assign UartDataOutReady = 1'b1;

endmodule

// File: tb/tb_uart_io_ctrl.sv
//-----------------------------------------------------------------------------
// tb_uart_io_ctrl
//
// Directed self-checking bench for uart_io_ctrl. Inputs change 1 ns after a
// rising edge and outputs are sampled at that same point, i.e. after the
// edge's updates have settled.
//-----------------------------------------------------------------------------
module tb_uart_io_ctrl;

  localparam logic [31:0] BASE     = 32'h8000_0000;
  localparam logic [31:0] A_STATUS = BASE + 32'h0;
  localparam logic [31:0] A_RX     = BASE + 32'h4;
  localparam logic [31:0] A_TX     = BASE + 32'h8;
  localparam logic [31:0] A_COUNT  = BASE + 32'hC;
  localparam logic [31:0] A_BAD    = BASE + 32'h10;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] WriteData = '0;
  logic        IOWrite = 1'b0;
  logic        IORead = 1'b0;
  logic [31:0] ReadData;
  logic [7:0]  UartDataIn;
  logic        UartDataInValid;
  logic        UartDataInReady = 1'b0;
  logic [7:0]  UartDataOut = '0;
  logic        UartDataOutValid = 1'b0;
  logic        UartDataOutReady;

  int pass_cnt  = 0;
  int total_cnt = 0;

  uart_io_ctrl #(.TX_DEPTH(4), .RX_DEPTH(4), .BASE(BASE)) dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .Addr             (Addr),
    .WriteData        (WriteData),
    .IOWrite          (IOWrite),
    .IORead           (IORead),
    .ReadData         (ReadData),
    .UartDataIn       (UartDataIn),
    .UartDataInValid  (UartDataInValid),
    .UartDataInReady  (UartDataInReady),
    .UartDataOut      (UartDataOut),
    .UartDataOutValid (UartDataOutValid),
    .UartDataOutReady (UartDataOutReady)
  );

  always #5 Clock = ~Clock;

  //---------------------------------------------------------------------------
  // Bus helpers (stimulus only)
  //---------------------------------------------------------------------------
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic io_read(input logic [31:0] a, output logic [31:0] d);
    Addr = a; IORead = 1'b1;
    tick();
    IORead = 1'b0;
    d = ReadData;
  endtask

  task automatic io_write(input logic [31:0] a, input logic [7:0] d);
    Addr = a; WriteData = {24'hABCDEF, d}; IOWrite = 1'b1;
    tick();
    IOWrite = 1'b0;
  endtask

  task automatic uart_push(input logic [7:0] d);
    UartDataOut = d; UartDataOutValid = 1'b1;
    tick();
    UartDataOutValid = 1'b0;
  endtask

  //---------------------------------------------------------------------------
  // Scenarios
  //---------------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] rd;
    Reset = 1'b0;
    tick(); tick();
    total_cnt++;
    if ({ReadData, UartDataInValid, UartDataOutReady} !== {32'h0, 1'b0, 1'b1})
      $display("FAIL reset_outputs: got rd=%h v=%b rdy=%b, want rd=0 v=0 rdy=1",
               ReadData, UartDataInValid, UartDataOutReady);
    else pass_cnt++;
    Reset = 1'b1;
    tick();
    io_read(A_STATUS, rd);
    total_cnt++;
    if (rd !== 32'h1) $display("FAIL reset_status: got %h want 00000001", rd);
    else pass_cnt++;
    io_read(A_COUNT, rd);
    total_cnt++;
    if (rd !== 32'h0) $display("FAIL reset_count: got %h want 00000000", rd);
    else pass_cnt++;
  endtask

  task automatic test_tx_drop();
    logic [31:0] rd;
    logic [7:0]  exp [4];
    exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43; exp[3] = 8'h44;
    UartDataInReady = 1'b0;
    io_write(A_TX, 8'h41);
    total_cnt++;
    if ({UartDataInValid, UartDataIn} !== {1'b1, 8'h41})
      $display("FAIL tx_push_latency: got v=%b d=%h want v=1 d=41", UartDataInValid, UartDataIn);
    else pass_cnt++;
    io_write(A_TX, 8'h42);
    io_write(A_TX, 8'h43);
    io_write(A_TX, 8'h44);
    io_write(A_TX, 8'h45);
    io_read(A_STATUS, rd);
    total_cnt++;
    if (rd !== 32'h8) $display("FAIL tx_drop_status: got %h want 00000008", rd);
    else pass_cnt++;
    io_read(A_COUNT, rd);
    total_cnt++;
    if (rd !== 32'h4) $display("FAIL tx_full_count: got %h want 00000004", rd);
    else pass_cnt++;
    io_read(A_STATUS, rd);
    total_cnt++;
    if (rd !== 32'h0) $display("FAIL tx_drop_cleared: got %h want 00000000", rd);
    else pass_cnt++;
    UartDataInReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if ({UartDataInValid, UartDataIn} !== {1'b1, exp[i]})
        $display("FAIL tx_drain_%0d: got v=%b d=%h want v=1 d=%h", i, UartDataInValid, UartDataIn, exp[i]);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (UartDataInValid !== 1'b0) $display("FAIL tx_drained_valid: got %b want 0", UartDataInValid);
    else pass_cnt++;
    UartDataInReady = 1'b0;
  endtask

  task automatic test_rx_basic();
    logic [31:0] rd;
    uart_push(8'h10);
    io_read(A_STATUS, rd);
    total_cnt++;
    if (rd !== 32'h3) $display("FAIL rx_basic_status: got %h want 00000003", rd);
    else pass_cnt++;
    io_read(A_RX, rd);
    total_cnt++;
    if (rd !== 32'h10) $display("FAIL rx_basic_data: got %h want 00000010", rd);
    else pass_cnt++;
    io_read(A_STATUS, rd);
    total_cnt++;
    if (rd !== 32'h1) $display("FAIL rx_basic_empty: got %h want 00000001", rd);
    else pass_cnt++;
  endtask

  task automatic test_rx_overflow();
    logic [31:0] rd;
    for (int i = 1; i <= 5; i++) uart_push(8'(i));
    io_read(A_STATUS, rd);
    total_cnt++;
    if (rd !== 32'h7) $display("FAIL rx_ovf_status: got %h want 00000007", rd);
    else pass_cnt++;
    io_read(A_STATUS, rd);
    total_cnt++;
    if (rd !== 32'h3) $display("FAIL rx_ovf_cleared: got %h want 00000003", rd);
    else pass_cnt++;
    for (int i = 1; i <= 4; i++) begin
      io_read(A_RX, rd);
      total_cnt++;
      if (rd !== 32'(i)) $display("FAIL rx_ovf_data_%0d: got %h want %h", i, rd, 32'(i));
      else pass_cnt++;
    end
  endtask

  task automatic test_rx_pop_push_full();
    logic [31:0] rd;
    logic [7:0]  exp [4];
    exp[0] = 8'hA1; exp[1] = 8'hA2; exp[2] = 8'hA3; exp[3] = 8'h99;
    for (int i = 0; i < 4; i++) uart_push(8'hA0 + 8'(i));
    UartDataOut = 8'h99; UartDataOutValid = 1'b1;
    io_read(A_RX, rd);
    UartDataOutValid = 1'b0;
    total_cnt++;
    if (rd !== 32'hA0) $display("FAIL rx_full_popush_data: got %h want 000000a0", rd);
    else pass_cnt++;
    io_read(A_STATUS, rd);
    total_cnt++;
    if (rd !== 32'h3) $display("FAIL rx_full_popush_noovf: got %h want 00000003", rd);
    else pass_cnt++;
    io_read(A_COUNT, rd);
    total_cnt++;
    if (rd !== 32'h400) $display("FAIL rx_full_popush_count: got %h want 00000400", rd);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      io_read(A_RX, rd);
      total_cnt++;
      if (rd !== {24'h0, exp[i]}) $display("FAIL rx_full_popush_drain_%0d: got %h want %h", i, rd, exp[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_status_race();
    logic [31:0] rd;
    for (int i = 0; i < 4; i++) uart_push(8'hC0 + 8'(i));
    // Overflow lands on the same edge as the clearing status read.
    UartDataOut = 8'hEE; UartDataOutValid = 1'b1;
    io_read(A_STATUS, rd);
    UartDataOutValid = 1'b0;
    total_cnt++;
    if (rd !== 32'h3) $display("FAIL race_status_pre: got %h want 00000003", rd);
    else pass_cnt++;
    io_read(A_STATUS, rd);
    total_cnt++;
    if (rd !== 32'h7) $display("FAIL race_ovf_kept: got %h want 00000007", rd);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) io_read(A_RX, rd);
    total_cnt++;
    if (rd !== 32'hC3) $display("FAIL race_last_byte: got %h want 000000c3", rd);
    else pass_cnt++;
    io_read(A_STATUS, rd);
    total_cnt++;
    if (rd !== 32'h1) $display("FAIL race_final_status: got %h want 00000001", rd);
    else pass_cnt++;
  endtask

  task automatic test_rx_empty_read();
    logic [31:0] rd;
    io_read(A_RX, rd);
    total_cnt++;
    if (rd !== 32'h0) $display("FAIL rx_empty_read: got %h want 00000000", rd);
    else pass_cnt++;
    io_read(A_STATUS, rd);
    total_cnt++;
    if (rd !== 32'h1) $display("FAIL rx_empty_noflag: got %h want 00000001", rd);
    else pass_cnt++;
  endtask

  task automatic test_tx_full_pop_push();
    logic [31:0] rd;
    logic [7:0]  exp [4];
    exp[0] = 8'h51; exp[1] = 8'h52; exp[2] = 8'h53; exp[3] = 8'h54;
    UartDataInReady = 1'b0;
    for (int i = 0; i < 4; i++) io_write(A_TX, 8'h50 + 8'(i));
    UartDataInReady = 1'b1;
    io_write(A_TX, 8'h54);
    UartDataInReady = 1'b0;
    io_read(A_COUNT, rd);
    total_cnt++;
    if (rd !== 32'h4) $display("FAIL tx_full_popush_count: got %h want 00000004", rd);
    else pass_cnt++;
    io_read(A_STATUS, rd);
    total_cnt++;
    if (rd !== 32'h0) $display("FAIL tx_full_popush_nodrop: got %h want 00000000", rd);
    else pass_cnt++;
    UartDataInReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if ({UartDataInValid, UartDataIn} !== {1'b1, exp[i]})
        $display("FAIL tx_full_popush_drain_%0d: got v=%b d=%h want v=1 d=%h", i, UartDataInValid, UartDataIn, exp[i]);
      else pass_cnt++;
      tick();
    end
    UartDataInReady = 1'b0;
  endtask

  task automatic test_rd_wr_same();
    logic [31:0] rd;
    io_read(A_STATUS, rd);
    Addr = A_TX; WriteData = 32'h0000_005A; IOWrite = 1'b1; IORead = 1'b1;
    tick();
    IOWrite = 1'b0; IORead = 1'b0;
    total_cnt++;
    if ({ReadData, UartDataInValid, UartDataIn} !== {32'h0, 1'b1, 8'h5A})
      $display("FAIL rd_wr_same: got rd=%h v=%b d=%h want rd=0 v=1 d=5a", ReadData, UartDataInValid, UartDataIn);
    else pass_cnt++;
    UartDataInReady = 1'b1;
    tick();
    UartDataInReady = 1'b0;
    total_cnt++;
    if (UartDataInValid !== 1'b0) $display("FAIL rd_wr_same_drain: got %b want 0", UartDataInValid);
    else pass_cnt++;
  endtask

  task automatic test_bad_addr();
    logic [31:0] rd;
    io_read(A_STATUS, rd);
    tick(); tick();
    total_cnt++;
    if (ReadData !== 32'h1) $display("FAIL read_hold: got %h want 00000001", ReadData);
    else pass_cnt++;
    io_read(A_BAD, rd);
    total_cnt++;
    if (rd !== 32'h0) $display("FAIL bad_addr_read: got %h want 00000000", rd);
    else pass_cnt++;
    io_write(A_BAD, 8'h77);
    io_write(A_STATUS, 8'h78);
    io_read(A_COUNT, rd);
    total_cnt++;
    if ({rd, UartDataInValid} !== {32'h0, 1'b0})
      $display("FAIL bad_addr_write: got cnt=%h v=%b want cnt=0 v=0", rd, UartDataInValid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    UartDataInReady = 1'b0;
    io_write(A_TX, 8'h61);
    io_write(A_TX, 8'h62);
    uart_push(8'h63);
    io_read(A_COUNT, rd);
    total_cnt++;
    if (rd !== 32'h0102) $display("FAIL reset_mid_precount: got %h want 00000102", rd);
    else pass_cnt++;
    Reset = 1'b0;
    #2;
    total_cnt++;
    if ({UartDataInValid, ReadData} !== {1'b0, 32'h0})
      $display("FAIL reset_mid_async: got v=%b rd=%h want v=0 rd=0", UartDataInValid, ReadData);
    else pass_cnt++;
    tick();
    Reset = 1'b1;
    tick();
    io_read(A_COUNT, rd);
    total_cnt++;
    if (rd !== 32'h0) $display("FAIL reset_mid_count: got %h want 00000000", rd);
    else pass_cnt++;
  endtask

  //---------------------------------------------------------------------------
  // Sequence
  //---------------------------------------------------------------------------
  initial begin
    #1;
    test_reset();
    test_tx_drop();
    test_rx_basic();
    test_rx_overflow();
    test_rx_pop_push_full();
    test_status_race();
    test_rx_empty_read();
    test_tx_full_pop_push();
    test_rd_wr_same();
    test_bad_addr();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_io_ctrl.md
# uart_io_ctrl

Memory-mapped UART controller between the CPU's IO load/store path and the UART core. It decodes the CPU's IO addresses, buffers transmit bytes and received bytes in two small FIFOs, and runs both UART valid/ready handshakes, so the CPU never has to meet a handshake cycle exactly. It returns registered read data and sticky error flags to the CPU.

## Interface
- TX_DEPTH, 4: transmit FIFO entries; power of two, ≥2.
- RX_DEPTH, 4: receive FIFO entries; power of two, ≥2.
- BASE, 32'h80000000: IO base address.
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Addr  in  32  CPU IO address.
- WriteData  in  32  CPU store data; only [7:0] is used.
- IOWrite  in  1  store strobe, one cycle per access.
- IORead  in  1  load strobe, one cycle per access.
- ReadData  out  32  registered load result.
- UartDataIn  out  8  byte to the UART transmitter.
- UartDataInValid  out  1  transmit byte valid.
- UartDataInReady  in  1  UART transmitter ready.
- UartDataOut  in  8  byte from the UART receiver.
- UartDataOutValid  in  1  received byte valid.
- UartDataOutReady  out  1  controller can accept a received byte.

## Operation
- Address map. Any other address: no side effect, and ReadData loads 0.
  - BASE+0x0, status, read: {28'b0, tx_drop, rx_ovf, rx_nonempty, tx_notfull}.
  - BASE+0x4, RX data, read: {24'b0, rx_head}, then pop.
  - BASE+0x8, TX data, write: push WriteData[7:0].
  - BASE+0xC, count, read: {16'b0, rx_count[7:0], tx_count[7:0]}.
- TX path.
  - UartDataInValid = tx_count≠0; UartDataIn = tx head entry.
  - Pop on the edge where UartDataInValid & UartDataInReady.
  - A CPU write while the FIFO is full is dropped and sets tx_drop.
  - A write and a pop in the same cycle when full: pop first, push accepted.
- RX path.
  - UartDataOutReady = 1 always; the controller absorbs bytes.
  - Push on UartDataOutValid & UartDataOutReady.
  - Push while the FIFO is full drops the incoming byte and sets rx_ovf; stored data is kept.
  - A CPU pop and a UART push in the same cycle when full: both happen, no overflow.
  - A CPU read of RX data while empty: ReadData=0, no pop, no flag.
- Status read. It reports values from before this edge's updates. It clears rx_ovf and tx_drop on the same edge; a new error event on that same edge wins, and the flag stays set.
- Simultaneous IORead and IOWrite: the write is performed; ReadData is still loaded.
- FIFOs use wrap-around pointers of log2(DEPTH) bits plus a separate count of log2(DEPTH)+1 bits. Count fields saturate to 8 bits when reported.

## Timing
- Reset values: ReadData=0, UartDataInValid=0, UartDataOutReady=1. Counts, pointers, rx_ovf and tx_drop are all 0.
- Reset asserted mid-transfer flushes both FIFOs immediately; the byte in flight is lost.
- Read latency 1: IORead sampled on edge N gives ReadData valid after edge N. ReadData holds until the next IORead.
- TX push latency: a byte written on edge N drives UartDataInValid=1 after edge N, when the FIFO was empty.
- RX visibility: a byte accepted on edge N shows rx_nonempty=1 to a status read issued at edge N+1.
- TX throughput is 1 byte/cycle when UartDataInReady stays high.
- Strobes are level-sampled each cycle. Holding IORead on RX data for k cycles pops k bytes.

## Test plan
- Reset, then status read → ReadData=0x00000001 (tx_notfull=1, rx empty). UartDataInValid=0.
- With UartDataInReady=0, write 0x41,0x42,0x43,0x44,0x45. Status → tx_drop=1, tx_notfull=0. Count read → 0x00000004. Raise ready → UART receives 0x41..0x44 on 4 consecutive edges.
- UART pushes 0x10 → status 0x3. RX read → 0x00000010. Next status → 0x1.
- Push 5 bytes 0x01..0x05 with no CPU reads → status 0x7. Status re-read → 0x3. Four RX reads → 0x01,0x02,0x03,0x04.
- RX FIFO full, UART push 0x99 on the same edge as a CPU RX read → read returns the oldest byte. rx_ovf stays 0. 0x99 becomes the last entry.
- Drop Reset to 0 with 2 TX bytes queued and UartDataInValid=1 → UartDataInValid=0 immediately. After release, count read → 0.
